// File: rtl/instr_fetch_unit_pkg.sv
// Shared sizing for the instruction fetch front end.
// Widths match the InstructionMemory this unit drives; RESET_PC_DEFAULT is
// the boot address used when the top-level parameter is left untouched.
package instr_fetch_unit_pkg;

  localparam int INSTR_ADDRW = 6;   // word address width
  localparam int INSTR_SIZE  = 32;  // instruction word width
  localparam int INSTR_DEPTH = 64;  // number of words in instruction memory

  localparam logic [INSTR_ADDRW-1:0] RESET_PC_DEFAULT = '0;

endpackage

// File: rtl/instr_fetch_unit.sv
// Purpose: owns the PC, drives instruction memory, builds the IF/ID register.
// Latency: address -> IF/ID is 2 edges; a redirect costs exactly one bubble.
// Backpressure: stall freezes IF/ID and replays the in-flight address.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   stall                 decode cannot accept this cycle
//   redirect, redirect_pc taken branch/jump and its word-address target
//   imem_addr, imem_data  instruction memory address (comb) / read data (1-cycle)
//   id_instr, id_pc       IF/ID instruction and its address
//   id_valid              IF/ID holds a live instruction
//   fetch_count           number of valid IF/ID captures (wraps)
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [INSTR_ADDRW-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [INSTR_ADDRW-1:0] redirect_pc,
  output logic [INSTR_ADDRW-1:0] imem_addr,
  input  logic [INSTR_SIZE-1:0]  imem_data,
  output logic [INSTR_SIZE-1:0]  id_instr,
  output logic [INSTR_ADDRW-1:0] id_pc,
  output logic                   id_valid,
  output logic [15:0]            fetch_count
);

  // Sequential word address with wrap at the end of memory.
  function automatic logic [INSTR_ADDRW-1:0] next_addr(input logic [INSTR_ADDRW-1:0] a);
    if (a == INSTR_ADDRW'(INSTR_DEPTH - 1)) return '0;
    return a + 1'b1;
  endfunction

  logic [INSTR_ADDRW-1:0] pc_q;        // next sequential address to issue
  logic [INSTR_ADDRW-1:0] fetch_pc_q;  // address of the word now on imem_data
  logic                   fetch_vld_q; // that word is live (not reset residue)

  // While stalled, re-issue the in-flight address so its data is still on
  // imem_data when the stall drops; no re-fetch cycle is needed.
  always_comb begin
    imem_addr = pc_q;
    if (redirect) begin
      imem_addr = redirect_pc;
    end else if (stall && fetch_vld_q) begin
      imem_addr = fetch_pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      fetch_pc_q  <= '0;
      fetch_vld_q <= 1'b0;
      id_instr    <= '0;
      id_pc       <= '0;
      id_valid    <= 1'b0;
      fetch_count <= '0;
    end else if (redirect) begin
      // Flush IF/ID and drop the in-flight word; the target is being read now.
      fetch_pc_q  <= redirect_pc;
      fetch_vld_q <= 1'b1;
      pc_q        <= next_addr(redirect_pc);
      id_valid    <= 1'b0;
    end else if (!stall) begin
      id_instr    <= imem_data;
      id_pc       <= fetch_pc_q;
      id_valid    <= fetch_vld_q;
      fetch_pc_q  <= pc_q;
      fetch_vld_q <= 1'b1;
      pc_q        <= next_addr(pc_q);
      if (fetch_vld_q) begin
        fetch_count <= fetch_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  typedef logic [INSTR_ADDRW-1:0] addr_t;
  typedef logic [INSTR_SIZE-1:0]  word_t;

  typedef struct {
    logic  stall;
    logic  redirect;
    addr_t rpc;
    addr_t exp_addr;  // imem_addr during the cycle, before the edge
    logic  exp_vld;   // id_valid after the edge
    addr_t exp_pc;    // id_pc after the edge (when exp_vld)
  } vec_t;

  typedef struct {
    addr_t pc;
    word_t instr;
  } sb_t;

  logic  clk;
  logic  rst_n;
  logic  stall;
  logic  redirect;
  addr_t redirect_pc;
  addr_t imem_addr;
  word_t imem_data;
  word_t id_instr;
  addr_t id_pc;
  logic  id_valid;
  logic [15:0] fetch_count;

  int n_vec;
  int n_bad;
  int delivered;

  vec_t vecs[$];
  sb_t  sb[$];

  instr_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_valid    (id_valid),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read ROM with rom[k] = k + 0x100.
  always @(posedge clk) imem_data <= word_t'(32'h100) + word_t'(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic r, input addr_t rpc,
                     input addr_t a, input logic v, input addr_t pc);
    vec_t t;
    t.stall = s; t.redirect = r; t.rpc = rpc;
    t.exp_addr = a; t.exp_vld = v; t.exp_pc = pc;
    vecs.push_back(t);
  endtask

  // Drive one cycle, check the address, push expectation, then check IF/ID.
  task automatic run_vec(input vec_t t);
    sb_t e;
    sb_t got;
    stall       = t.stall;
    redirect    = t.redirect;
    redirect_pc = t.rpc;
    #1;
    chk("imem_addr", 32'(imem_addr), 32'(t.exp_addr));
    if (t.exp_vld) begin
      e.pc    = t.exp_pc;
      e.instr = word_t'(32'h100) + word_t'(t.exp_pc);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    chk("id_valid", 32'(id_valid), 32'(t.exp_vld));
    if (t.exp_vld) begin
      if (sb.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL scoreboard: empty queue, expected an entry");
      end else begin
        got = sb.pop_front();
        chk("id_pc", 32'(id_pc), 32'(got.pc));
        chk("id_instr", 32'(id_instr), 32'(got.instr));
        // New capture only when the edge was neither a stall nor a redirect.
        if (id_valid && !t.stall && !t.redirect) delivered++;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0; n_bad = 0; delivered = 0;
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

    // Reset release, sequential fetch from 0.
    add(0,0,'0,  6'd0, 0, 6'd0);
    add(0,0,'0,  6'd1, 1, 6'd0);
    add(0,0,'0,  6'd2, 1, 6'd1);
    add(0,0,'0,  6'd3, 1, 6'd2);
    add(0,0,'0,  6'd4, 1, 6'd3);
    add(0,0,'0,  6'd5, 1, 6'd4);
    // Stall three cycles with id_pc = 4: address 5 is replayed.
    add(1,0,'0,  6'd5, 1, 6'd4);
    add(1,0,'0,  6'd5, 1, 6'd4);
    add(1,0,'0,  6'd5, 1, 6'd4);
    add(0,0,'0,  6'd6, 1, 6'd5);
    add(0,0,'0,  6'd7, 1, 6'd6);
    add(0,0,'0,  6'd8, 1, 6'd7);
    // Redirect to 0x20 while id_pc = 7: one bubble.
    add(0,1,6'h20, 6'h20, 0, 6'd0);
    add(0,0,'0,    6'h21, 1, 6'h20);
    add(0,0,'0,    6'h22, 1, 6'h21);
    // Redirect together with stall: redirect wins.
    add(1,1,6'h30, 6'h30, 0, 6'd0);
    add(0,0,'0,    6'h31, 1, 6'h30);
    add(0,0,'0,    6'h32, 1, 6'h31);
    // Fetch across the last address.
    add(0,1,6'h3e, 6'h3e, 0, 6'd0);
    add(0,0,'0,    6'h3f, 1, 6'h3e);
    add(0,0,'0,    6'h00, 1, 6'h3f);
    add(0,0,'0,    6'h01, 1, 6'h00);
    add(0,0,'0,    6'h02, 1, 6'h01);
    // Enter a stall that reset will interrupt.
    add(1,0,'0,    6'h02, 1, 6'h01);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst id_valid", 32'(id_valid), 32'd0);
    chk("rst id_pc", 32'(id_pc), 32'd0);
    chk("rst id_instr", 32'(id_instr), 32'd0);
    chk("rst fetch_count", 32'(fetch_count), 32'd0);
    chk("rst imem_addr", 32'(imem_addr), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    chk("fetch_count pre-reset", 32'(fetch_count), 32'd16);
    chk("delivered pre-reset", 32'(delivered), 32'd16);

    // Reset asserted mid-stall takes effect without waiting for an edge.
    stall = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async id_valid", 32'(id_valid), 32'd0);
    chk("async fetch_count", 32'(fetch_count), 32'd0);
    chk("async imem_addr", 32'(imem_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    delivered = 0;
    sb.delete();

    vecs.delete();
    // Stall with no live word in flight: address stays at pc_q.
    add(1,0,'0, 6'd0, 0, 6'd0);
    add(1,0,'0, 6'd0, 0, 6'd0);
    add(0,0,'0, 6'd0, 0, 6'd0);
    add(0,0,'0, 6'd1, 1, 6'd0);
    add(0,0,'0, 6'd2, 1, 6'd1);
    add(0,0,'0, 6'd3, 1, 6'd2);
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    chk("fetch_count end", 32'(fetch_count), 32'(delivered));
    chk("delivered end", 32'(delivered), 32'd3);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
